// File: rtl/inst_rom_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_defs
//   Shared definitions for the instruction-ROM boot loader: the loader FSM
//   state encoding, the byte/word/length widths, and a helper that checks a
//   frame's word count against the ROM capacity.
// ---------------------------------------------------------------------------
package loader_defs;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CSUM   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // True when a frame asks for more words than a 2^addr_w-word ROM holds.
  // The comparison is done one bit wider than the length so that a full
  // 2^LEN_W capacity is still representable.
  function automatic logic len_too_big(input logic [LEN_W-1:0] n,
                                       input int               addr_w);
    return {1'b0, n} > ((LEN_W + 1)'(1) << addr_w);
  endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// ---------------------------------------------------------------------------
// inst_rom_loader_if
//   Bundles the loader's byte-stream input and its ROM write port.
//   Ports (by modport):
//     master : the side that feeds bytes and observes the ROM write port
//              (byte source / top-level glue).
//     slave  : the loader itself; consumes s_valid/s_data, drives s_ready
//              and the rom_we/rom_addr/rom_data write strobe.
// ---------------------------------------------------------------------------
interface inst_rom_loader_if
  import loader_defs::*;
#(
  parameter int ADDR_W = 10
) ();

  logic              s_valid;
  logic [BYTE_W-1:0] s_data;
  logic              s_ready;

  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, rom_we, rom_addr, rom_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, rom_we, rom_addr, rom_data
  );

endinterface

// File: rtl/inst_rom_loader_byte_to_word.sv
// ---------------------------------------------------------------------------
// byte_to_word
//   Packs a byte stream into big-endian 32-bit words. The first byte of a
//   word ends up in bits [31:24]. word_valid/word are combinational and
//   asserted in the same cycle the 4th byte is presented, so the caller can
//   register them together with its own write address.
//   Ports:
//     clk, rst    : clock, synchronous active-low reset
//     clear       : drop any partial word (restart of a frame)
//     byte_valid  : byte_in is consumed this cycle
//     byte_in     : stream byte
//     word_valid  : 4th byte of a word is being consumed this cycle
//     word        : assembled word, valid with word_valid
// ---------------------------------------------------------------------------
module byte_to_word
  import loader_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  localparam int SHIFT_W = WORD_W - BYTE_W;

  logic [1:0]         cnt_q,   cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;

  // The three earlier bytes sit in shift_q; the current byte completes it.
  assign word = {shift_q, byte_in};

  // NOTE: every signal driven here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word_valid = 1'b0;
    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid) begin
      shift_d    = {shift_q[SHIFT_W-BYTE_W-1:0], byte_in};
      cnt_d      = cnt_q + 2'd1;
      word_valid = (cnt_q == 2'd3);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// ---------------------------------------------------------------------------
// inst_rom_loader
//   Boot-time writer for the instruction ROM. Receives a frame
//     LEN_HI LEN_LO {4*N data bytes, big-endian words} CSUM
//   writes the N words to ROM addresses 0..N-1 and releases the CPU core
//   from reset once the checksum (data bytes + CSUM == 0 mod 256) holds.
//   Ports:
//     clk, rst : clock, synchronous active-low reset
//     bus      : slave side of inst_rom_loader_if (byte stream in,
//                ROM write port out; rom_* registered, one-cycle rom_we)
//     reload   : restart loading, honoured only in DONE/ERR
//     cpu_rst  : active-high CPU reset, released only after a good frame
//     done     : frame loaded and verified
//     err      : length or checksum error
//   ADDR_W must not exceed the 16-bit length field.
// ---------------------------------------------------------------------------
module inst_rom_loader
  import loader_defs::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  inst_rom_loader_if.slave bus,
  input  logic             reload,
  output logic             cpu_rst,
  output logic             done,
  output logic             err
);

  state_e            state_q,    state_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
  logic [BYTE_W-1:0] sum_q,      sum_d;
  logic              rom_we_q,   rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [WORD_W-1:0] rom_data_q, rom_data_d;
  logic              cpu_rst_q,  cpu_rst_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;

  logic              s_ready;
  logic              accept;
  logic              reload_go;
  logic              word_valid;
  logic [WORD_W-1:0] word;
  logic [BYTE_W-1:0] csum_total;

  // s_ready is gated by rst so the source sees back-pressure during reset.
  assign s_ready   = rst && (state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM});
  assign accept    = bus.s_valid && s_ready;
  assign reload_go = reload && (state_q inside {ST_DONE, ST_ERR});
  assign csum_total = sum_q + bus.s_data;

  byte_to_word u_byte_to_word (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload_go),
    .byte_valid (accept && (state_q == ST_DATA)),
    .byte_in    (bus.s_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    sum_d      = sum_q;
    rom_we_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;

    unique case (state_q)
      ST_LEN_HI: begin
        if (accept) begin
          len_d   = {bus.s_data, len_q[BYTE_W-1:0]};
          state_d = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        if (accept) begin
          len_d = {len_q[LEN_W-1:BYTE_W], bus.s_data};
          if (len_d == '0) begin
            // Empty program: only the checksum byte follows.
            state_d = ST_CSUM;
          end else if (len_too_big(len_d, ADDR_W)) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          sum_d = csum_total;
          if (word_valid) begin
            rom_we_d   = 1'b1;
            rom_addr_d = word_cnt_q[ADDR_W-1:0];
            rom_data_d = word;
            word_cnt_d = word_cnt_q + LEN_W'(1);
            if (word_cnt_q == len_q - LEN_W'(1)) begin
              state_d = ST_CSUM;
            end
          end
        end
      end

      ST_CSUM: begin
        if (accept) begin
          if (csum_total == '0) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end

      ST_DONE, ST_ERR: begin
        if (reload_go) begin
          state_d    = ST_LEN_HI;
          len_d      = '0;
          word_cnt_d = '0;
          sum_d      = '0;
          cpu_rst_d  = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
      end

      default: state_d = ST_LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_LEN_HI;
      len_q      <= '0;
      word_cnt_q <= '0;
      sum_q      <= '0;
      rom_we_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      sum_q      <= sum_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.rom_we   = rom_we_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_data = rom_data_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_loader
//   Drives two loaders (ADDR_W = 10 and ADDR_W = 4) from one byte driver,
//   selecting which one sees s_valid/reload. Expected ROM writes and final
//   status come from a frame-level model that parses the byte list directly.
// ---------------------------------------------------------------------------
module tb_inst_rom_loader;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       reload;
  logic       sel;      // 0: ADDR_W=10 loader, 1: ADDR_W=4 loader

  logic cpu_rst10, done10, err10;
  logic cpu_rst4,  done4,  err4;
  logic s_ready_sel, cpu_rst_sel, done_sel, err_sel;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  wr_t        wr_q[$];
  logic [7:0] frame[$];

  // Frame-level expectations
  logic [9:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_bidx[$];
  int          exp_nbytes;
  logic        exp_done;
  logic        exp_err;

  inst_rom_loader_if #(.ADDR_W(10)) bus10 ();
  inst_rom_loader_if #(.ADDR_W(4))  bus4 ();

  assign bus10.s_valid = s_valid & ~sel;
  assign bus10.s_data  = s_data;
  assign bus4.s_valid  = s_valid & sel;
  assign bus4.s_data   = s_data;

  inst_rom_loader #(.ADDR_W(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus10),
    .reload  (reload & ~sel),
    .cpu_rst (cpu_rst10),
    .done    (done10),
    .err     (err10)
  );

  inst_rom_loader #(.ADDR_W(4)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus4),
    .reload  (reload & sel),
    .cpu_rst (cpu_rst4),
    .done    (done4),
    .err     (err4)
  );

  assign s_ready_sel = sel ? bus4.s_ready : bus10.s_ready;
  assign cpu_rst_sel = sel ? cpu_rst4     : cpu_rst10;
  assign done_sel    = sel ? done4        : done10;
  assign err_sel     = sel ? err4         : err10;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with rom_we high is logged; a strobe longer than one cycle
  // therefore shows up as an extra write.
  always @(negedge clk) begin
    if (bus10.rom_we) wr_q.push_back('{addr: bus10.rom_addr, data: bus10.rom_data, cyc: cyc});
    if (bus4.rom_we)  wr_q.push_back('{addr: 10'(bus4.rom_addr), data: bus4.rom_data, cyc: cyc});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  task automatic model_frame(input int aw);
    int n;
    int sum;
    exp_addr.delete();
    exp_data.delete();
    exp_bidx.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = {frame[0], frame[1]};
    if (n > (1 << aw)) begin
      exp_err    = 1'b1;
      exp_nbytes = 2;
      return;
    end
    sum = 0;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(10'(i));
      exp_data.push_back({frame[2+4*i], frame[3+4*i], frame[4+4*i], frame[5+4*i]});
      exp_bidx.push_back(5 + 4*i);
      for (int k = 0; k < 4; k++) sum += int'(frame[2+4*i+k]);
    end
    exp_nbytes = 3 + 4*n;
    if ((sum + int'(frame[2+4*n])) % 256 == 0) exp_done = 1'b1;
    else                                     exp_err  = 1'b1;
  endtask

  task automatic build_frame(input int n, input bit good);
    int  sum;
    logic [7:0] b, cs;
    frame.delete();
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    sum = 0;
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
      sum += int'(b);
    end
    cs = 8'((256 - (sum % 256)) % 256);
    if (!good) cs = cs + 8'($urandom_range(1, 255));
    frame.push_back(cs);
  endtask

  task automatic set_frame(input logic [7:0] bytes[]);
    frame.delete();
    foreach (bytes[i]) frame.push_back(bytes[i]);
  endtask

  // -------------------------------------------------------------- driver
  // gap: 0 = s_valid held high, 1 = every other cycle, 2 = random.
  // noise: toggle reload randomly while the frame is in flight.
  task automatic run_frame(input int gap, input bit noise, input string tag);
    int   idx, budget, limit;
    int   acc[$];
    logic v;
    model_frame(sel ? 4 : 10);
    wr_q.delete();
    idx    = 0;
    budget = 0;
    limit  = exp_nbytes * 8 + 50;
    while (idx < exp_nbytes) begin
      @(negedge clk);
      case (gap)
        0:       v = 1'b1;
        1:       v = (budget % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = frame[idx];
      reload  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (v) begin
        checks++;
        if (s_ready_sel !== 1'b1) begin
          failures++;
          $display("FAIL %s s_ready at byte %0d: got %b want 1", tag, idx, s_ready_sel);
          break;
        end
        if (idx == exp_nbytes - 1) begin
          checks++;
          if (done_sel !== 1'b0 || err_sel !== 1'b0) begin
            failures++;
            $display("FAIL %s early status: done=%b err=%b want 0 0", tag, done_sel, err_sel);
          end
        end
        acc.push_back(cyc + 1);
        idx++;
      end
      budget++;
      if (budget > limit) begin
        checks++;
        failures++;
        $display("FAIL %s timeout after %0d cycles at byte %0d", tag, budget, idx);
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    reload  = 1'b0;
    checks++;
    if (done_sel !== exp_done || err_sel !== exp_err || cpu_rst_sel !== !exp_done ||
        s_ready_sel !== 1'b0) begin
      failures++;
      $display("FAIL %s status: done=%b err=%b cpu_rst=%b s_ready=%b want %b %b %b 0",
               tag, done_sel, err_sel, cpu_rst_sel, s_ready_sel, exp_done, exp_err, !exp_done);
    end
    // Bytes offered in DONE/ERR must be ignored.
    s_valid = 1'b1;
    s_data  = 8'h5A;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (done_sel !== exp_done || err_sel !== exp_err) begin
      failures++;
      $display("FAIL %s hold: done=%b err=%b want %b %b", tag, done_sel, err_sel, exp_done, exp_err);
    end
    checks++;
    if (wr_q.size() != exp_addr.size()) begin
      failures++;
      $display("FAIL %s write count: got %0d want %0d", tag, wr_q.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < wr_q.size(); i++) begin
      int want_cyc;
      want_cyc = (exp_bidx[i] < acc.size()) ? acc[exp_bidx[i]] : -1;
      checks++;
      if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i] ||
          wr_q[i].cyc != want_cyc) begin
        failures++;
        $display("FAIL %s write[%0d]: addr=%0h data=%08h cyc=%0d want addr=%0h data=%08h cyc=%0d",
                 tag, i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc,
                 exp_addr[i], exp_data[i], want_cyc);
      end
    end
  endtask

  task automatic pulse_reload(input logic which, input string tag);
    @(negedge clk);
    sel     = which;
    s_valid = 1'b0;
    reload  = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    checks++;
    if (cpu_rst_sel !== 1'b1 || done_sel !== 1'b0 || err_sel !== 1'b0 || s_ready_sel !== 1'b1) begin
      failures++;
      $display("FAIL %s reload: cpu_rst=%b done=%b err=%b s_ready=%b want 1 0 0 1",
               tag, cpu_rst_sel, done_sel, err_sel, s_ready_sel);
    end
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; reload = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus10.rom_we !== 1'b0 || bus10.rom_addr !== 10'h0 || bus10.rom_data !== 32'h0 ||
        cpu_rst10 !== 1'b1 || done10 !== 1'b0 || err10 !== 1'b0 || bus10.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset10: we=%b addr=%0h data=%08h cpu_rst=%b done=%b err=%b s_ready=%b",
               bus10.rom_we, bus10.rom_addr, bus10.rom_data, cpu_rst10, done10, err10, bus10.s_ready);
    end
    checks++;
    if (bus4.rom_we !== 1'b0 || bus4.rom_addr !== 4'h0 || bus4.rom_data !== 32'h0 ||
        cpu_rst4 !== 1'b1 || done4 !== 1'b0 || err4 !== 1'b0 || bus4.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset4: we=%b addr=%0h data=%08h cpu_rst=%b done=%b err=%b s_ready=%b",
               bus4.rom_we, bus4.rom_addr, bus4.rom_data, cpu_rst4, done4, err4, bus4.s_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus10.s_ready !== 1'b1 || bus4.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset release s_ready: got %b %b want 1 1", bus10.s_ready, bus4.s_ready);
    end
  endtask

  task automatic test_basic_frame();
    sel = 1'b0;
    set_frame('{8'h00, 8'h02, 8'h3C, 8'h02, 8'h04, 8'h04, 8'h00, 8'h02, 8'h12, 8'h00, 8'hA6});
    run_frame(0, 1'b0, "basic");
    checks++;
    if (wr_q.size() != 2 || wr_q[0].data !== 32'h3C020404 || wr_q[1].data !== 32'h00021200 ||
        wr_q[1].addr !== 10'd1 || done10 !== 1'b1 || cpu_rst10 !== 1'b0) begin
      failures++;
      $display("FAIL basic words: n=%0d done=%b cpu_rst=%b want 2 writes 3c020404,00021200 done=1 cpu_rst=0",
               wr_q.size(), done10, cpu_rst10);
    end
  endtask

  task automatic test_bad_csum();
    pulse_reload(1'b0, "bad_csum");
    set_frame('{8'h00, 8'h02, 8'h3C, 8'h02, 8'h04, 8'h04, 8'h00, 8'h02, 8'h12, 8'h00, 8'h00});
    run_frame(0, 1'b0, "bad_csum");
    checks++;
    if (err10 !== 1'b1 || done10 !== 1'b0 || cpu_rst10 !== 1'b1 || wr_q.size() != 2) begin
      failures++;
      $display("FAIL bad_csum status: err=%b done=%b cpu_rst=%b writes=%0d want 1 0 1 2",
               err10, done10, cpu_rst10, wr_q.size());
    end
    pulse_reload(1'b0, "after_err");
    build_frame(3, 1'b1);
    run_frame(0, 1'b0, "after_err");
  endtask

  task automatic test_empty_frame();
    pulse_reload(1'b0, "empty");
    set_frame('{8'h00, 8'h00, 8'h00});
    run_frame(0, 1'b0, "empty");
  endtask

  task automatic test_len_limit();
    pulse_reload(1'b1, "len17");
    build_frame(17, 1'b1);
    run_frame(0, 1'b0, "len17");
    checks++;
    if (err4 !== 1'b1 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL len17: err=%b writes=%0d want 1 0", err4, wr_q.size());
    end
    pulse_reload(1'b1, "len16");
    build_frame(16, 1'b1);
    run_frame(0, 1'b0, "len16");
    checks++;
    if (done4 !== 1'b1 || wr_q.size() != 16 || wr_q[15].addr !== 10'd15) begin
      failures++;
      $display("FAIL len16: done=%b writes=%0d want 1 16 ending at addr 15", done4, wr_q.size());
    end
  endtask

  task automatic test_gaps();
    pulse_reload(1'b0, "toggle");
    set_frame('{8'h00, 8'h02, 8'h3C, 8'h02, 8'h04, 8'h04, 8'h00, 8'h02, 8'h12, 8'h00, 8'hA6});
    run_frame(1, 1'b1, "toggle");
    pulse_reload(1'b0, "rand_gap");
    build_frame(5, 1'b1);
    run_frame(2, 1'b1, "rand_gap");
  endtask

  task automatic test_rst_mid_frame();
    logic [7:0] head[4];
    head = '{8'h00, 8'h02, 8'h3C, 8'h02};
    pulse_reload(1'b0, "rst_mid");
    wr_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = head[i];
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready_sel !== 1'b0 || cpu_rst_sel !== 1'b1 || done_sel !== 1'b0 || bus10.rom_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid in reset: s_ready=%b cpu_rst=%b done=%b we=%b want 0 1 0 0",
               s_ready_sel, cpu_rst_sel, done_sel, bus10.rom_we);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (s_ready_sel !== 1'b1 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL rst_mid after reset: s_ready=%b writes=%0d want 1 0", s_ready_sel, wr_q.size());
    end
    // A full frame straight after must line up from LEN_HI with no stale bytes.
    set_frame('{8'h00, 8'h02, 8'h3C, 8'h02, 8'h04, 8'h04, 8'h00, 8'h02, 8'h12, 8'h00, 8'hA6});
    run_frame(0, 1'b0, "rst_mid_refill");
  endtask

  task automatic test_overwrite();
    pulse_reload(1'b0, "overwrite");
    set_frame('{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04});
    run_frame(0, 1'b0, "overwrite");
    checks++;
    if (wr_q.size() != 1 || wr_q[0].addr !== 10'd0 || wr_q[0].data !== 32'hFFFFFFFF || done10 !== 1'b1) begin
      failures++;
      $display("FAIL overwrite: writes=%0d done=%b want one write ffffffff at 0 and done=1",
               wr_q.size(), done10);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      logic which;
      int   n;
      which = 1'($urandom_range(0, 1));
      n     = $urandom_range(0, which ? 18 : 12);
      pulse_reload(which, "random");
      build_frame(n, $urandom_range(0, 3) != 0);
      run_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bad_csum();
    test_empty_frame();
    test_len_limit();
    test_gaps();
    test_rst_mid_frame();
    test_overwrite();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
